// File: rtl/mem_pkg.sv
// Shared definitions for the two-port RAM access controller:
// access type codes, controller states, port identifiers and
// the alignment / read-data sizing helpers.
package mem_pkg;

    // Access type codes as seen on the RAM typeData pins
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    // Requester identifiers; also the bit index in the arbiter request vector
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // WAIT cycles allowed without moc before an access is aborted
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESP    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Alignment/legality of an access: only the two low address bits matter
    function automatic logic access_ok(input logic [1:0] typ, input logic [1:0] addr_lo);
        logic ok;
        case (typ)
            BYTE:    ok = 1'b1;
            HALF:    ok = (addr_lo[0] == 1'b0);
            WORD:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Zero-extend the right-justified RAM output to the access size
    function automatic logic [31:0] size_rdata(input logic [1:0] typ, input logic [31:0] dout);
        logic [31:0] res;
        case (typ)
            BYTE:    res = {24'h000000, dout[7:0]};
            HALF:    res = {16'h0000, dout[15:0]};
            default: res = dout;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter. Request bit PORT_IF is the fetch port,
// bit PORT_D the data port. The last-grant memory only moves when both
// ports contend, so a lone requester never steals the next tie.
module mem_rr_arbiter
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    // Pick a requester; on a tie favour the port that did not win last time
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last_grant == PORT_D) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Remember the winner of each contended grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_D;
        end else if (i_advance && (i_req == 2'b11)) begin
            r_last_grant <= o_grant[1] ? PORT_D : PORT_IF;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port (fetch / data) controller in front of a 256-byte RAM with an
// mv/moc handshake. Arbitrates, checks alignment, sequences the handshake
// with a timeout and returns a one-cycle ready/err with sized read data.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_mv,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_type,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_moc,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic               r_port;
    logic               r_touched;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0]         w_grant;
    logic               w_sel_port;
    logic               w_sel_rw;
    logic [1:0]         w_sel_type;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_ok;
    logic [DATA_W-1:0]  w_rd_sized;

    mem_rr_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({d_req, if_req}),
        .i_advance (r_state == ST_IDLE),
        .o_grant   (w_grant)
    );

    // Access attributes of the granted port; fetch is always a word read
    always_comb begin
        w_sel_port  = PORT_IF;
        w_sel_rw    = 1'b1;
        w_sel_type  = WORD;
        w_sel_addr  = if_addr;
        w_sel_wdata = {DATA_W{1'b0}};
        if (w_grant[1]) begin
            w_sel_port  = PORT_D;
            w_sel_rw    = d_rw;
            w_sel_type  = d_type;
            w_sel_addr  = d_addr;
            w_sel_wdata = d_wdata;
        end else begin
            w_sel_port  = PORT_IF;
        end
    end

    assign w_sel_ok   = access_ok(w_sel_type, w_sel_addr[1:0]);
    assign w_rd_sized = size_rdata(mem_type, mem_dout);
    assign busy       = r_busy;

    // Access sequencer: state, RAM-side outputs and requester responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_port    <= PORT_IF;
            r_touched <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            mem_mv    <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_type  <= 2'b00;
            mem_din   <= {DATA_W{1'b0}};
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_port <= w_sel_port;
                        r_busy <= 1'b1;
                        if (w_sel_ok) begin
                            // Setup values go out now so they are stable a cycle before mv
                            r_state   <= ST_ISSUE;
                            r_touched <= 1'b1;
                            mem_rw    <= w_sel_rw;
                            mem_addr  <= w_sel_addr;
                            mem_type  <= w_sel_type;
                            mem_din   <= w_sel_wdata;
                        end else begin
                            // Rejected access: answer with err, RAM pins untouched
                            r_state   <= ST_RESP;
                            r_touched <= 1'b0;
                            if (w_sel_port == PORT_D) begin
                                d_ready <= 1'b1;
                                d_err   <= 1'b1;
                            end else begin
                                if_ready <= 1'b1;
                                if_err   <= 1'b1;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= {CNT_W{1'b0}};
                    mem_mv  <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_moc) begin
                        mem_mv  <= 1'b0;
                        r_state <= ST_RESP;
                        if (r_port == PORT_D) begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_rw ? w_rd_sized : {DATA_W{1'b0}};
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= w_rd_sized;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_mv  <= 1'b0;
                        r_state <= ST_RESP;
                        if (r_port == PORT_D) begin
                            d_ready <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            if_ready <= 1'b1;
                            if_err   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if_ready <= 1'b0;
                    if_err   <= 1'b0;
                    if_rdata <= {DATA_W{1'b0}};
                    d_ready  <= 1'b0;
                    d_err    <= 1'b0;
                    d_rdata  <= {DATA_W{1'b0}};
                    if (r_touched) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // RAM must drop moc before the next access may start
                    if (!mem_moc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RELEASE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    mem_mv  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: big-endian byte RAM model,
// table of single accesses plus arbitration, timeout, reset and
// moc-hold sequences. Expected responses go through a scoreboard queue.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_type;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_mv;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_type;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_moc;
    logic        busy;

    mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_mv(mem_mv), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_type(mem_type),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_moc(mem_moc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (big-endian, right-justified data) ----------------
    logic [7:0] ram [256];
    logic [7:0] a1, a2, a3;
    logic       moc_block;
    logic       moc_hold;
    assign a1 = mem_addr + 8'd1;
    assign a2 = mem_addr + 8'd2;
    assign a3 = mem_addr + 8'd3;
    assign mem_moc = (mem_mv & ~moc_block) | moc_hold;

    always_comb begin
        case (mem_type)
            2'b00:   mem_dout = {24'hC3C3C3, ram[mem_addr]};
            2'b01:   mem_dout = {16'hC3C3, ram[mem_addr], ram[a1]};
            default: mem_dout = {ram[mem_addr], ram[a1], ram[a2], ram[a3]};
        endcase
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_mv && !mem_rw && mem_moc) begin
            case (mem_type)
                2'b00: ram[mem_addr] <= mem_din[7:0];
                2'b01: begin ram[mem_addr] <= mem_din[15:8]; ram[a1] <= mem_din[7:0]; end
                default: begin
                    ram[mem_addr] <= mem_din[31:24]; ram[a1] <= mem_din[23:16];
                    ram[a2] <= mem_din[15:8];        ram[a3] <= mem_din[7:0];
                end
            endcase
        end
    end

    // ---------------- Bus monitors ----------------
    int          mv_cycles = 0;
    int          ready_cnt = 0;
    logic [1:0]  seen_type = 2'b00;
    logic        seen_rw   = 1'b0;
    logic [7:0]  seen_addr = 8'h00;
    logic [31:0] seen_din  = 32'h0;

    always @(posedge clk) begin
        if (rst_n && mem_mv) begin
            mv_cycles <= mv_cycles + 1;
            seen_type <= mem_type;
            seen_rw   <= mem_rw;
            seen_addr <= mem_addr;
            seen_din  <= mem_din;
        end
    end

    always @(negedge clk) begin
        if (if_ready || d_ready) ready_cnt <= ready_cnt + 1;
    end

    // ---------------- Checking infrastructure ----------------
    typedef struct {
        logic        fetch;
        logic        rw;
        logic [1:0]  typ;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next ready pulse, compare it against the scoreboard
    task automatic wait_ready_pop(output int lat);
        exp_t e;
        logic got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (if_ready || d_ready) begin
                got = 1'b1;
                check("ready_onehot", {31'b0, if_ready & d_ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("port", {31'b0, d_ready}, {31'b0, e.port});
                    check("rdata", d_ready ? d_rdata : if_rdata, e.rdata);
                    check("err", {31'b0, d_ready ? d_err : if_err}, {31'b0, e.err});
                end
                if (d_ready) d_req = 1'b0;
                else if_req = 1'b0;
            end
        end
        check("ready_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic drive(input vec_t v);
        if (v.fetch) begin
            if_addr = v.addr;
            if_req  = 1'b1;
        end else begin
            d_rw    = v.rw;
            d_type  = v.typ;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_req   = 1'b1;
        end
    endtask

    // One complete access from the table with latency and RAM-pin checks
    task automatic do_access(input vec_t v);
        int lat;
        int mv0;
        mv0 = mv_cycles;
        push_exp(v.fetch ? PORT_IF : PORT_D, v.rdata, v.err);
        drive(v);
        wait_ready_pop(lat);
        check("latency", lat, v.err ? 32'd1 : 32'd3);
        @(negedge clk);
        check("ready_pulse", {31'b0, if_ready | d_ready}, 32'd0);
        wait_idle();
        if (v.err) begin
            check("no_ram_touch", mv_cycles - mv0, 32'd0);
        end else begin
            check("mv_cycles", mv_cycles - mv0, 32'd1);
            check("mem_type", {30'b0, seen_type}, {30'b0, v.fetch ? WORD : v.typ});
            check("mem_rw", {31'b0, seen_rw}, {31'b0, v.fetch ? 1'b1 : v.rw});
            check("mem_addr", {24'b0, seen_addr}, {24'b0, v.addr});
            if (!v.fetch && !v.rw) check("mem_din", seen_din, v.wdata);
        end
    endtask

    // ---------------- Test sequence ----------------
    initial begin
        int lat;
        int mv0;
        int rc0;
        vec_t v;

        // fetch rw typ addr wdata exp_rdata exp_err
        vecs[0]  = '{1'b0, 1'b0, WORD,  8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, BYTE,  8'h11, 32'h00000000, 32'h000000AD, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, HALF,  8'h12, 32'h00000000, 32'h0000BEEF, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, WORD,  8'h10, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, WORD,  8'h10, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, BYTE,  8'h13, 32'hFFFFFF5A, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, WORD,  8'h10, 32'h00000000, 32'hDEADBE5A, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, HALF,  8'hFE, 32'h00001234, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, WORD,  8'hFC, 32'h00000000, 32'h00001234, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, HALF,  8'h21, 32'h00000000, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, WORD,  8'h22, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 2'b11, 8'h00, 32'h00000000, 32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 1'b0, WORD,  8'h01, 32'h11111111, 32'h00000000, 1'b1};
        vecs[13] = '{1'b1, 1'b1, WORD,  8'h02, 32'h00000000, 32'h00000000, 1'b1};
        vecs[14] = '{1'b1, 1'b1, WORD,  8'hFC, 32'h00000000, 32'h00001234, 1'b0};
        vecs[15] = '{1'b0, 1'b1, BYTE,  8'hFF, 32'h00000000, 32'h00000034, 1'b0};

        rst_n = 1'b0; if_req = 1'b0; if_addr = 8'h00;
        d_req = 1'b0; d_rw = 1'b1; d_type = 2'b00; d_addr = 8'h00; d_wdata = 32'h0;
        moc_block = 1'b0; moc_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mem_mv", {31'b0, mem_mv}, 32'd0);
        check("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
        check("rst_mem_pins", {22'b0, mem_addr, mem_type}, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_ready_err", {28'b0, if_ready, if_err, d_ready, d_err}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arbitration: both high from reset -> fetch first, then data
        push_exp(PORT_IF, 32'h0, 1'b0);
        push_exp(PORT_D,  32'h0, 1'b0);
        if_addr = 8'h40; if_req = 1'b1;
        d_rw = 1'b1; d_type = WORD; d_addr = 8'h44; d_req = 1'b1;
        wait_ready_pop(lat);
        check("arb1_latency", lat, 32'd3);
        wait_ready_pop(lat);
        wait_idle();
        // Second tie -> data first, then fetch
        push_exp(PORT_D,  32'h0, 1'b0);
        push_exp(PORT_IF, 32'h0, 1'b0);
        if_addr = 8'h48; if_req = 1'b1;
        d_rw = 1'b1; d_type = WORD; d_addr = 8'h4C; d_req = 1'b1;
        wait_ready_pop(lat);
        wait_ready_pop(lat);
        wait_idle();

        // Table of single accesses
        for (int i = 0; i < 16; i++) do_access(vecs[i]);

        // Timeout: RAM withholds moc
        moc_block = 1'b1;
        mv0 = mv_cycles;
        v = '{1'b0, 1'b1, WORD, 8'h20, 32'h0, 32'h0, 1'b1};
        push_exp(PORT_D, 32'h0, 1'b1);
        drive(v);
        wait_ready_pop(lat);
        check("timeout_latency", lat, 32'd18);
        check("timeout_mv_low", {31'b0, mem_mv}, 32'd0);
        moc_block = 1'b0;
        wait_idle();
        check("timeout_wait_cycles", mv_cycles - mv0, 32'd16);

        // Asynchronous reset in WAIT
        moc_block = 1'b1;
        v = '{1'b0, 1'b1, WORD, 8'h30, 32'h0, 32'h0, 1'b0};
        drive(v);
        repeat (4) @(negedge clk);
        check("pre_rst_mv", {31'b0, mem_mv}, 32'd1);
        rc0 = ready_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mv", {31'b0, mem_mv}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        d_req = 1'b0;
        moc_block = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_ready", ready_cnt - rc0, 32'd0);
        do_access('{1'b0, 1'b0, WORD, 8'h30, 32'hCAFEF00D, 32'h0, 1'b0});
        do_access('{1'b0, 1'b1, WORD, 8'h30, 32'h0, 32'hCAFEF00D, 1'b0});

        // moc held high after RESP keeps the controller in RELEASE
        v = '{1'b0, 1'b1, HALF, 8'h32, 32'h0, 32'h0, 1'b0};
        push_exp(PORT_D, 32'h0000F00D, 1'b0);
        drive(v);
        wait_ready_pop(lat);
        moc_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("release_busy", {31'b0, busy}, 32'd1);
        end
        moc_hold = 1'b0;
        @(negedge clk);
        check("release_to_idle", {31'b0, busy}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Two-port controller in front of the 256-byte RAM (8-bit address, 32-bit data bus, byte/halfword/word access via a 2-bit type code, mv/moc handshake).
- Arbitrates between an instruction-fetch port (word reads only) and a data port (byte/half/word read and write).
- Checks alignment, sequences the mv/moc handshake with a timeout, returns size-extended read data and a one-cycle ready/err to the granted requester.

Parameters:
ADDR_W, 8, byte address width
DATA_W, 32, data bus width
TIMEOUT, 16, WAIT cycles without moc before the access aborts with err

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held high until if_ready
if_addr  in  8  fetch byte address
if_ready  out  1  one-cycle completion pulse to fetch port
if_rdata  out  32  fetched word; valid while if_ready=1
if_err  out  1  with if_ready: misaligned or timeout
d_req  in  1  data request; held high until d_ready
d_rw  in  1  1=read, 0=write
d_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal
d_addr  in  8  data byte address
d_wdata  in  32  write data, right-justified (byte in [7:0], half in [15:0])
d_ready  out  1  one-cycle completion pulse to data port
d_rdata  out  32  read data, zero-extended; valid while d_ready=1
d_err  out  1  with d_ready: misaligned, illegal type or timeout
mem_mv  out  1  memory valid to RAM
mem_rw  out  1  to RAM rw
mem_addr  out  8  to RAM address
mem_type  out  2  to RAM typeData
mem_din  out  32  to RAM DataIn
mem_dout  in  32  from RAM DataOut
mem_moc  in  1  memory operation complete from RAM
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: clk, rst_n (async assert, active-low). On assertion, immediately: state IDLE; mem_mv=0, mem_rw=1, mem_addr=0, mem_type=0, mem_din=0; all ready/err=0; rdata=0; timeout counter=0; last_grant=DATA (fetch wins the first tie). Reset mid-access drops mem_mv at once; the in-flight request is discarded with no ready pulse.
- States: IDLE, ISSUE, WAIT, RESP, RELEASE.
- IDLE: if neither req high, stay. One req high: grant it. Both high: grant the port not equal to last_grant, then update last_grant. Latch addr/type/rw/wdata (fetch forces rw=1, type=10). Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; type 11 illegal. Fail -> RESP with err=1; RAM is never touched. Pass -> ISSUE.
- ISSUE (1 cycle): drive mem_rw/addr/type/din from latches, mem_mv=0 (setup cycle); clear counter -> WAIT.
- WAIT: mem_mv=1, all mem_* stable. moc=1 sampled -> capture read data -> RESP. Otherwise counter++; counter=TIMEOUT-1 without moc -> RESP with err=1.
- Read-data sizing: byte {24'b0,dout[7:0]}; half {16'b0,dout[15:0]}; word dout. Write: d_wdata passed unchanged.
- RESP (1 cycle): mem_mv=0; pulse ready (and err if flagged) to the granted port only; rdata valid this cycle. -> RELEASE, or IDLE if the RAM was never touched.
- RELEASE: mem_mv=0; wait for mem_moc=0, then IDLE. No timeout here.
- Minimum latency: req high at edge N -> ready high in the cycle after edge N+3 (IDLE->ISSUE->WAIT->RESP, moc immediate). Back-to-back accesses are spaced by at least one RELEASE/IDLE cycle.
- Protocol violation: req dropped before ready -> the access still completes and ready still pulses. The other port's req is only sampled in IDLE.
- Address wrap cannot occur: aligned word at 0xFC covers 0xFC-0xFF.

Decomposition:
- Package mem_pkg: type codes (BYTE=2'b00, HALF=2'b01, WORD=2'b10), state enum, port IDs (PORT_IF, PORT_D), default TIMEOUT.
- Sub-module mem_rr_arbiter: 2-way round-robin with last_grant register; inputs req[1:0] and an advance strobe; outputs a one-hot grant.

Test Plan:
- Data word write 0xDEADBEEF @0x10, then byte read @0x11 -> mem_type=10 on write; read d_rdata=0x000000AD, d_err=0.
- Halfword read @0x21 -> d_ready+d_err in the cycle after edge 1 (IDLE->RESP); mem_mv never asserted.
- if_req and d_req both high from reset -> fetch served first, data second; repeat with both high -> data first.
- RAM model withholds moc -> after TIMEOUT=16 WAIT cycles, ready+err pulse, mem_mv=0, back in IDLE.
- rst_n low in WAIT -> mem_mv=0 asynchronously, no ready pulse; after release, new request completes normally.
- moc held high 5 cycles after RESP -> controller stays in RELEASE, busy=1; IDLE in the cycle after moc falls.
